viterbi_frame_ctrl: RTL

VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

---
 rtl/viterbi_pkg.sv | 22 ++
 rtl/vfc_counter.sv | 34 +++
 rtl/viterbi_frame_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared state encoding, default frame constants and width helper
package viterbi_pkg;

  localparam int unsigned FRAME_LEN_DEF = 32;
  localparam int unsigned TAIL_LEN_DEF  = 2;
  localparam int unsigned TBL_DEF       = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DATA,
    ST_TAIL,
    ST_FLUSH,
    ST_DONE
  } vfc_state_e;

  // Bits needed to hold max_val (at least one).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/vfc_counter.sv
// rtl/vfc_counter.sv - up-counter with clear, enable and terminal-count flag
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   clr  - synchronous clear to zero (wins over en)
//   en   - count up by one
//   tc   - high while the count equals TERMINAL
module vfc_counter
  import viterbi_pkg::*;
#(
  parameter int unsigned TERMINAL = 1,
  parameter int unsigned WIDTH    = cnt_width(TERMINAL)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// rtl/viterbi_frame_ctrl.sv - frame sequencer between symbol PISO, Viterbi core and bit SIPO
//
// Optional feature macro: VITERBI_FRAME_WDOG_EN (FLUSH watchdog plus err_o port).
//
// Ports:
//   clk, rst                  - clock and synchronous active-high reset
//   start_i                   - begin a frame (only honoured while idle)
//   sym_valid_i/sym_data_i    - upstream symbol stream, sym_ready_o handshake
//   core_valid_o/core_data_o  - symbols (data, then zero tail/flush) to the decoder core
//   core_clr_o                - one-cycle clear of core metrics/history
//   dec_valid_i/dec_bit_i     - decoded bits from the core
//   out_valid_o/out_bit_o     - first FRAME_LEN decoded bits forwarded downstream
//   busy_o, done_o            - frame in progress / one-cycle completion pulse
//   err_o                     - watchdog expiry pulse (only with VITERBI_FRAME_WDOG_EN)
//   frame_cnt_o               - completed frame count, wraps 255->0
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned TAIL_LEN  = TAIL_LEN_DEF,
  parameter int unsigned TBL       = TBL_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       sym_valid_i,
  input  logic [1:0] sym_data_i,
  output logic       sym_ready_o,
  output logic       core_valid_o,
  output logic [1:0] core_data_o,
  output logic       core_clr_o,
  input  logic       dec_valid_i,
  input  logic       dec_bit_i,
  output logic       out_valid_o,
  output logic       out_bit_o,
  output logic       busy_o,
  output logic       done_o,
`ifdef VITERBI_FRAME_WDOG_EN
  output logic       err_o,
`endif
  output logic [7:0] frame_cnt_o
);

  localparam bit HAS_TAIL = (TAIL_LEN != 0);

  vfc_state_e state, next_state;

  logic counting;
  logic xfer;
  logic sym_last;
  logic tail_last;
  logic out_last;
  logic out_full;
  logic out_fwd;
  logic out_done_now;
  logic [7:0] frame_cnt;

  // Decoded bits are only accepted from CLEAR exit until the frame is complete.
  assign counting = (state == ST_DATA) || (state == ST_TAIL) || (state == ST_FLUSH);
  assign xfer     = (state == ST_DATA) && sym_valid_i;
  assign out_fwd  = counting && dec_valid_i && !out_full;
  // Complete either already, or with the bit being forwarded this cycle, so the
  // FSM never spends an idle FLUSH cycle waiting for a registered flag.
  assign out_done_now = out_full || (out_fwd && out_last);

  vfc_counter #(.TERMINAL(FRAME_LEN - 1)) u_sym_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state == ST_CLEAR),
    .en  (xfer),
    .tc  (sym_last)
  );

  vfc_counter #(.TERMINAL(HAS_TAIL ? TAIL_LEN - 1 : 0)) u_tail_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state != ST_TAIL),
    .en  (state == ST_TAIL),
    .tc  (tail_last)
  );

  // Counts forwarded bits; tc marks the FRAME_LEN-th one, after which out_full
  // holds and further bits are dropped.
  vfc_counter #(.TERMINAL(FRAME_LEN - 1)) u_out_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state == ST_CLEAR),
    .en  (out_fwd),
    .tc  (out_last)
  );

`ifdef VITERBI_FRAME_WDOG_EN
  logic wd_last;
  logic wd_expire;
  logic err_q;

  // Cleared whenever outside FLUSH, so it restarts from zero on FLUSH entry.
  vfc_counter #(.TERMINAL(4 * TBL - 1)) u_wd_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state != ST_FLUSH),
    .en  (state == ST_FLUSH),
    .tc  (wd_last)
  );

  assign wd_expire = (state == ST_FLUSH) && wd_last && !out_done_now;
  assign err_o     = err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      frame_cnt <= 8'd0;
      out_full  <= 1'b0;
`ifdef VITERBI_FRAME_WDOG_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (state == ST_DONE) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (state == ST_CLEAR) begin
        out_full <= 1'b0;
      end else if (out_fwd && out_last) begin
        out_full <= 1'b1;
      end
`ifdef VITERBI_FRAME_WDOG_EN
      err_q <= wd_expire;
`endif
    end
  end

  always_comb begin
    next_state   = state;
    sym_ready_o  = 1'b0;
    core_valid_o = 1'b0;
    core_data_o  = 2'b00;
    core_clr_o   = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        core_clr_o = 1'b1;
        next_state = ST_DATA;
      end
      ST_DATA: begin
        sym_ready_o  = 1'b1;
        core_valid_o = sym_valid_i;
        core_data_o  = sym_valid_i ? sym_data_i : 2'b00;
        if (xfer && sym_last) begin
          if (HAS_TAIL)          next_state = ST_TAIL;
          else if (out_done_now) next_state = ST_DONE;
          else                   next_state = ST_FLUSH;
        end
      end
      ST_TAIL: begin
        core_valid_o = 1'b1;
        if (tail_last) next_state = out_done_now ? ST_DONE : ST_FLUSH;
      end
      ST_FLUSH: begin
        core_valid_o = 1'b1;
        if (out_done_now) next_state = ST_DONE;
`ifdef VITERBI_FRAME_WDOG_EN
        else if (wd_expire) next_state = ST_IDLE;
`endif
      end
      ST_DONE: begin
        done_o     = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign out_valid_o = out_fwd;
  assign out_bit_o   = out_fwd ? dec_bit_i : 1'b0;
  assign frame_cnt_o = frame_cnt;

endmodule
